// File: rtl/uni_window_decoder.sv
// Unipolar bitstream decoder: counts ones over 2^WLOG valid samples behind a start/busy/done handshake.
// Define UNI_WINDOW_DECODER_BIPOLAR_EN to report 2*ones - 2^WLOG as a two's-complement value instead.
module uni_window_decoder #(
    parameter int WLOG = 8,
    parameter int CONT = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            in,
    input  logic            in_valid,
    output logic            busy,
    output logic            done,
`ifdef UNI_WINDOW_DECODER_BIPOLAR_EN
    output logic [WLOG+1:0] out
`else
    output logic [WLOG:0]   out
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WLOG-1:0] SC_LAST = '1;

    state_t          state_reg;
    logic [WLOG-1:0] sc_reg;
    logic [WLOG:0]   oc_reg;
    logic [WLOG:0]   oc_next;

    // Count including the current sample, so the last sample lands directly in out.
    assign oc_next = oc_reg + {{WLOG{1'b0}}, in};

`ifdef UNI_WINDOW_DECODER_BIPOLAR_EN
    localparam logic [WLOG+1:0] HALF_SCALE = (WLOG+2)'(1) << WLOG;
    logic [WLOG+1:0] out_next;
    assign out_next = {oc_next, 1'b0} - HALF_SCALE;
`else
    logic [WLOG:0] out_next;
    assign out_next = oc_next;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            sc_reg    <= '0;
            oc_reg    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out       <= '0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg <= RUN;
                        busy      <= 1'b1;
                        sc_reg    <= '0;
                        oc_reg    <= '0;
                    end
                end
                RUN: begin
                    if (in_valid) begin
                        if (sc_reg == SC_LAST) begin
                            state_reg <= DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            out       <= out_next;
                        end else begin
                            sc_reg <= sc_reg + 1'b1;
                            oc_reg <= oc_next;
                        end
                    end
                end
                DONE: begin
                    // Samples presented here are dropped; re-arm clears counters for the next window.
                    if ((CONT != 0) || start) begin
                        state_reg <= RUN;
                        busy      <= 1'b1;
                        sc_reg    <= '0;
                        oc_reg    <= '0;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uni_window_decoder.sv
// Directed bench for uni_window_decoder: one-shot (CONT=0) and continuous (CONT=1) instances, WLOG=4.
module tb_uni_window_decoder;

    localparam int WLOG = 4;
`ifdef UNI_WINDOW_DECODER_BIPOLAR_EN
    localparam int OW = WLOG + 2;
`else
    localparam int OW = WLOG + 1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start0 = 1'b0;
    logic start1 = 1'b0;
    logic in_bit = 1'b0;
    logic in_valid = 1'b0;
    logic busy0, done0, busy1, done1;
    logic [OW-1:0] out0, out1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uni_window_decoder #(.WLOG(WLOG), .CONT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .in(in_bit), .in_valid(in_valid),
        .busy(busy0), .done(done0), .out(out0)
    );

    uni_window_decoder #(.WLOG(WLOG), .CONT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .in(in_bit), .in_valid(in_valid),
        .busy(busy1), .done(done1), .out(out1)
    );

    function automatic logic [OW-1:0] exp_out(input int ones);
`ifdef UNI_WINDOW_DECODER_BIPOLAR_EN
        return OW'(2 * ones - (1 << WLOG));
`else
        return OW'(ones);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy0: got %b expected 0", busy0); end
        checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL reset_done0: got %b expected 0", done0); end
        checks++; if (out0 !== '0) begin errors++; $display("FAIL reset_out0: got %0d expected 0", out0); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy1: got %b expected 0", busy1); end
        checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL reset_done1: got %b expected 0", done1); end
        checks++; if (out1 !== '0) begin errors++; $display("FAIL reset_out1: got %0d expected 0", out1); end
        rst_n = 1'b1;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_all_ones();
        start0 = 1'b1; in_bit = 1'b1; in_valid = 1'b1;
        tick();
        start0 = 1'b0;
        for (int k = 1; k <= 22; k++) begin
            checks++;
            if (busy0 !== (k <= 16)) begin errors++; $display("FAIL all_ones_busy cycle %0d: got %b expected %b", k, busy0, (k <= 16)); end
            checks++;
            if (done0 !== (k == 17)) begin errors++; $display("FAIL all_ones_done cycle %0d: got %b expected %b", k, done0, (k == 17)); end
            if (k >= 17) begin
                checks++;
                if (out0 !== exp_out(16)) begin errors++; $display("FAIL all_ones_out cycle %0d: got %0d expected %0d", k, out0, exp_out(16)); end
            end
            tick();
        end
        $display("test_all_ones out=%0d", out0);
    endtask

    task automatic test_pattern(input logic [15:0] pat, input int ones, input string nm);
        start0 = 1'b1; in_valid = 1'b1; in_bit = 1'b0;
        tick();
        start0 = 1'b0;
        for (int k = 1; k <= 19; k++) begin
            checks++;
            if (done0 !== (k == 17)) begin errors++; $display("FAIL %s_done cycle %0d: got %b expected %b", nm, k, done0, (k == 17)); end
            checks++;
            if (busy0 !== (k <= 16)) begin errors++; $display("FAIL %s_busy cycle %0d: got %b expected %b", nm, k, busy0, (k <= 16)); end
            if (k >= 17) begin
                checks++;
                if (out0 !== exp_out(ones)) begin errors++; $display("FAIL %s_out cycle %0d: got %0d expected %0d", nm, k, out0, exp_out(ones)); end
            end
            in_bit = (k <= 16) ? pat[k-1] : 1'b1;
            tick();
        end
        $display("test_pattern %s out=%0d", nm, out0);
    endtask

    // Bubble on every third RUN cycle: 7 bubbles before the 16th valid sample (RUN cycle 23), done at 24.
    task automatic test_bubbles();
        start0 = 1'b1; in_bit = 1'b1; in_valid = 1'b1;
        tick();
        start0 = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            checks++;
            if (done0 !== (k == 24)) begin errors++; $display("FAIL bubble_done cycle %0d: got %b expected %b", k, done0, (k == 24)); end
            checks++;
            if (busy0 !== (k <= 23)) begin errors++; $display("FAIL bubble_busy cycle %0d: got %b expected %b", k, busy0, (k <= 23)); end
            if (k >= 24) begin
                checks++;
                if (out0 !== exp_out(16)) begin errors++; $display("FAIL bubble_out cycle %0d: got %0d expected %0d", k, out0, exp_out(16)); end
            end
            in_valid = (k % 3) != 0;
            tick();
        end
        in_valid = 1'b1;
        $display("test_bubbles out=%0d", out0);
    endtask

    // Start in RUN (cycle 5) ignored; start in DONE (cycle 17) begins a second window.
    task automatic test_start_in_run_and_done();
        for (int k = 0; k <= 36; k++) begin
            if (k > 0) begin
                checks++;
                if (done0 !== (k == 17 || k == 34)) begin errors++; $display("FAIL restart_done cycle %0d: got %b", k, done0); end
                checks++;
                if (busy0 !== ((k >= 1 && k <= 16) || (k >= 18 && k <= 33))) begin errors++; $display("FAIL restart_busy cycle %0d: got %b", k, busy0); end
                if (k >= 17) begin
                    checks++;
                    if (out0 !== exp_out(k >= 34 ? 16 : 8)) begin errors++; $display("FAIL restart_out cycle %0d: got %0d expected %0d", k, out0, exp_out(k >= 34 ? 16 : 8)); end
                end
            end
            start0 = (k == 0 || k == 5 || k == 17);
            in_bit = (k <= 16) ? ((k % 2) == 1) : 1'b1;
            in_valid = 1'b1;
            tick();
        end
        start0 = 1'b0;
        $display("test_start_in_run_and_done out=%0d", out0);
    endtask

    task automatic test_cont();
        for (int k = 0; k <= 40; k++) begin
            if (k > 0) begin
                checks++;
                if (done1 !== (k == 17 || k == 34)) begin errors++; $display("FAIL cont_done cycle %0d: got %b", k, done1); end
                checks++;
                if (busy1 !== !(k == 17 || k == 34)) begin errors++; $display("FAIL cont_busy cycle %0d: got %b", k, busy1); end
                if (k >= 17) begin
                    checks++;
                    if (out1 !== exp_out(k >= 34 ? 0 : 16)) begin errors++; $display("FAIL cont_out cycle %0d: got %0d expected %0d", k, out1, exp_out(k >= 34 ? 0 : 16)); end
                end
            end
            start1 = (k == 0);
            in_bit = (k <= 17);
            in_valid = 1'b1;
            tick();
        end
        $display("test_cont out=%0d", out1);
    endtask

    task automatic test_cont_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        for (int k = 0; k <= 40; k++) begin
            if (k > 0) begin
                checks++;
                if (done1 !== (k == 17)) begin errors++; $display("FAIL rst_done cycle %0d: got %b", k, done1); end
                checks++;
                if (busy1 !== ((k >= 1 && k <= 16) || (k >= 18 && k <= 25))) begin errors++; $display("FAIL rst_busy cycle %0d: got %b", k, busy1); end
                if (k >= 17 && k <= 25) begin
                    checks++;
                    if (out1 !== exp_out(16)) begin errors++; $display("FAIL rst_out_pre cycle %0d: got %0d expected %0d", k, out1, exp_out(16)); end
                end
                if (k >= 26) begin
                    checks++;
                    if (out1 !== '0) begin errors++; $display("FAIL rst_out_post cycle %0d: got %0d expected 0", k, out1); end
                end
            end
            if (k == 25) begin
                rst_n = 1'b0;
                #1;
                checks++;
                if (out1 !== '0 || busy1 !== 1'b0 || done1 !== 1'b0) begin
                    errors++; $display("FAIL rst_async cycle 25: out=%0d busy=%b done=%b expected 0 0 0", out1, busy1, done1);
                end
            end
            if (k == 26) rst_n = 1'b1;
            start1 = (k == 0);
            in_bit = (k <= 17);
            in_valid = 1'b1;
            tick();
        end
        start1 = 1'b0;
        $display("test_cont_reset out=%0d", out1);
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_pattern(16'h5555, 8, "alternating");
        test_pattern(16'h0000, 0, "zeros");
        test_bubbles();
        test_start_in_run_and_done();
        test_cont();
        test_cont_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
